// File: rtl/traffic_ctrl.sv
// Two-road traffic light controller with all-red clearance, night flash mode and
// an optional pedestrian walk phase enabled by macro TRAFFIC_CTRL_PED_EN.
module traffic_ctrl #(
  parameter int CNT_W    = 16,
  parameter int T_GREEN  = 300,
  parameter int T_YELLOW = 50,
  parameter int T_CLR    = 4,
  parameter int T_WALK   = 200,
  parameter int T_FLASH  = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flash,
  input  logic       ped_req,
  output logic       a_red,
  output logic       a_yellow,
  output logic       a_green,
  output logic       b_red,
  output logic       b_yellow,
  output logic       b_green,
  output logic       ped_walk,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ALL_RED_A = 3'd0,
    A_GREEN   = 3'd1,
    A_YELLOW  = 3'd2,
    ALL_RED_B = 3'd3,
    B_GREEN   = 3'd4,
    B_YELLOW  = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(T_CLR - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(T_FLASH - 1);

  state_t           cur;
  state_t           next_normal;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] last_cnt;
  logic             at_last;
  logic             blink;

`ifdef TRAFFIC_CTRL_PED_EN
  logic ped_pend;
`else
  logic unused_ped;
  assign unused_ped = ped_req;
`endif

  always_comb begin
    last_cnt = CLR_LAST;
    case (cur)
      ALL_RED_A, ALL_RED_B: last_cnt = CLR_LAST;
      A_GREEN, B_GREEN:     last_cnt = GREEN_LAST;
      A_YELLOW, B_YELLOW:   last_cnt = YELLOW_LAST;
      PED_WALK:             last_cnt = WALK_LAST;
      FLASH:                last_cnt = FLASH_LAST;
      default:              last_cnt = CLR_LAST;
    endcase
  end

  assign at_last = (timer == last_cnt);

  always_comb begin
    next_normal = ALL_RED_A;
    case (cur)
      ALL_RED_A: next_normal = A_GREEN;
      A_GREEN:   next_normal = A_YELLOW;
      A_YELLOW:  next_normal = ALL_RED_B;
      ALL_RED_B: next_normal = B_GREEN;
      B_GREEN:   next_normal = B_YELLOW;
`ifdef TRAFFIC_CTRL_PED_EN
      B_YELLOW:  next_normal = ped_pend ? PED_WALK : ALL_RED_A;
`else
      B_YELLOW:  next_normal = ALL_RED_A;
`endif
      default:   next_normal = ALL_RED_A;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur   <= ALL_RED_A;
      timer <= '0;
      blink <= 1'b1;
`ifdef TRAFFIC_CTRL_PED_EN
      ped_pend <= 1'b0;
`endif
    end else begin
      timer <= timer + 1'b1;
`ifdef TRAFFIC_CTRL_PED_EN
      ped_pend <= ped_pend | ped_req;
`endif
      if (cur == FLASH) begin
        if (!flash) begin
          cur   <= ALL_RED_A;
          timer <= '0;
        end else if (at_last) begin
          timer <= '0;
          blink <= ~blink;
        end
      end else if (at_last) begin
        timer <= '0;
        // flash is only honoured at the end of a clearance interval
        if ((cur == ALL_RED_A || cur == ALL_RED_B) && flash) begin
          cur   <= FLASH;
          blink <= 1'b1;
        end else begin
          cur <= next_normal;
        end
`ifdef TRAFFIC_CTRL_PED_EN
        if (cur == B_YELLOW && ped_pend)
          ped_pend <= ped_req;
`endif
      end
    end
  end

  always_comb begin
    a_red    = 1'b1;
    a_yellow = 1'b0;
    a_green  = 1'b0;
    b_red    = 1'b1;
    b_yellow = 1'b0;
    b_green  = 1'b0;
    ped_walk = 1'b0;
    case (cur)
      A_GREEN:  begin a_red = 1'b0; a_green  = 1'b1; end
      A_YELLOW: begin a_red = 1'b0; a_yellow = 1'b1; end
      B_GREEN:  begin b_red = 1'b0; b_green  = 1'b1; end
      B_YELLOW: begin b_red = 1'b0; b_yellow = 1'b1; end
`ifdef TRAFFIC_CTRL_PED_EN
      PED_WALK: ped_walk = 1'b1;
`endif
      FLASH: begin
        a_red    = 1'b0;
        b_red    = 1'b0;
        a_yellow = blink;
        b_yellow = blink;
      end
      default: ;
    endcase
  end

  assign state = cur;

endmodule

// File: doc/traffic_ctrl.md
TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, state-timer width in bits.
REQ-002 SHALL have parameter T_GREEN, default 300, green duration in cycles.
REQ-003 SHALL have parameter T_YELLOW, default 50, yellow duration in cycles.
REQ-004 SHALL have parameter T_CLR, default 4, all-red clearance duration in cycles.
REQ-005 SHALL have parameter T_WALK, default 200, pedestrian walk duration in cycles.
REQ-006 SHALL have parameter T_FLASH, default 25, flash half-period in cycles.
REQ-007 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port flash  input  1  level request for night/flashing-yellow mode.
REQ-010 SHALL have port ped_req  input  1  pedestrian button, any width pulse.
REQ-011 SHALL have ports a_red, a_yellow, a_green  output  1 each  main-road lamps.
REQ-012 SHALL have ports b_red, b_yellow, b_green  output  1 each  side-road lamps.
REQ-013 SHALL have port ped_walk  output  1  pedestrian walk lamp.
REQ-014 SHALL have port state  output  3  current state code.

Function
REQ-015 SHALL implement states ALL_RED_A=0, A_GREEN=1, A_YELLOW=2, ALL_RED_B=3, B_GREEN=4, B_YELLOW=5, PED_WALK=6, FLASH=7.
REQ-016 SHALL keep each timed state for exactly its duration: ALL_RED_x T_CLR, x_GREEN T_GREEN, x_YELLOW T_YELLOW, PED_WALK T_WALK cycles; timer counts 0..T-1, then clears to 0 on transition.
REQ-017 SHALL sequence ALL_RED_A -> A_GREEN -> A_YELLOW -> ALL_RED_B -> B_GREEN -> B_YELLOW -> (PED_WALK if ped_pend) -> ALL_RED_A.
REQ-018 SHALL drive lamps as Moore outputs decoded from state: exactly one of red/yellow/green per road high outside FLASH; a road is red whenever the other is not red.
REQ-019 SHALL latch ped_req into internal ped_pend; ped_pend clears on the cycle PED_WALK is entered; simultaneous set and clear leaves ped_pend set.
REQ-020 SHALL drive ped_walk=1 only in PED_WALK, with all six vehicle lamps red.
REQ-021 SHALL sample flash only on the final cycle of an ALL_RED_x state; if high, next state is FLASH instead of the normal successor.
REQ-022 SHALL, in FLASH, drive reds and greens 0 and both yellows equal to a blink bit toggling every T_FLASH cycles, starting at 1.
REQ-023 SHALL leave FLASH for ALL_RED_A, timer 0, on the cycle after flash is sampled low; ped_pend is retained through FLASH.
REQ-024 SHALL require every T_* >= 1 and < 2**CNT_W; timer never wraps.

Reset
REQ-025 SHALL, on reset assertion at any time, force state ALL_RED_A, timer 0, ped_pend 0, blink 1, without waiting for clock.
REQ-026 SHALL show during reset: a_red=b_red=1, all other lamps 0, ped_walk 0, state 0.
REQ-027 SHALL begin the first ALL_RED_A timer count on the first posedge after reset deasserts.

Configuration
REQ-028 SHALL honour macro TRAFFIC_CTRL_PED_EN: defined -> ped_pend, PED_WALK and ped_walk behave per REQ-019/020.
REQ-029 SHALL, without TRAFFIC_CTRL_PED_EN, ignore ped_req, tie ped_walk 0, make B_YELLOW always go to ALL_RED_A, and omit PED_WALK logic.

Verification
REQ-030 SHALL cover: T_GREEN=5,T_YELLOW=2,T_CLR=1, no requests -> 16-cycle period, states 0,1x5,2x2,3,4x5,5x2 repeating.
REQ-031 SHALL cover: PED_EN, T_WALK=3, 1-cycle ped_req during A_GREEN -> after B_YELLOW, state 6 for 3 cycles, ped_walk=1, all reds 1; next round no walk.
REQ-032 SHALL cover: ped_req held high on the PED_WALK entry cycle -> ped_pend stays set, walk repeats next round.
REQ-033 SHALL cover: flash=1 raised in A_GREEN -> A_YELLOW completes, FLASH entered after ALL_RED_B; with T_FLASH=2 yellows go 1,1,0,0,...; flash=0 -> state 0 next cycle.
REQ-034 SHALL cover: reset pulsed mid-B_GREEN, between clock edges -> lamps immediately a_red=b_red=1, state 0; sequence restarts per REQ-030.
REQ-035 SHALL cover: PED_EN undefined, ped_req pulsed -> ped_walk stays 0, sequence identical to REQ-030.
